spi_shift_engine: RTL and testbench
===================================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter SIZE, default 8, frame width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(SIZE), bit-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a frame; loads dataIn.
REQ-006 clear  input  1  synchronous abort; zeroes the register and returns to IDLE.
REQ-007 bit_tick  input  1  one-cycle strobe; advances one bit per strobe.
REQ-008 lsb_first  input  1  bit-order select, sampled only on an accepted start.
REQ-009 serIn  input  1  serial receive bit, captured on bit_tick.
REQ-010 dataIn  input  SIZE  parallel frame to transmit.
REQ-011 serOut  output  1  current transmit bit.
REQ-012 dataOut  output  SIZE  shift register contents.
REQ-013 busy  output  1  high while the FSM is in SHIFT.
REQ-014 done  output  1  one-cycle pulse at frame completion.
REQ-015 bit_cnt  output  CNT_W  bits shifted so far in the current frame.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE.
- Encoded as registers.
- busy = (state==SHIFT).
- done = (state==DONE).
REQ-017 IDLE with start=1 -> next cycle:
- dataOut = dataIn.
- bit_cnt = 0.
- order latched from lsb_first.
- state = SHIFT.
REQ-018 IDLE ignores bit_tick; dataOut holds.
REQ-019 SHIFT with bit_tick, MSB-first: dataOut <= {dataOut[SIZE-2:0], serIn}.
REQ-020 SHIFT with bit_tick, LSB-first: dataOut <= {serIn, dataOut[SIZE-1:1]}.
REQ-021 Each SHIFT tick increments bit_cnt. A tick with bit_cnt==SIZE-1 -> state DONE and bit_cnt returns to 0.
REQ-022 serOut is combinational from dataOut:
- dataOut[SIZE-1] when MSB-first.
- dataOut[0] when LSB-first.
- Valid from the cycle after start is accepted.
REQ-023 DONE lasts exactly one cycle, then IDLE. dataOut holds the received frame in DONE and IDLE until the next start or clear.
REQ-024 start in SHIFT or DONE is ignored; no reload, no counter change.
REQ-025 Latency: done asserts the cycle after the SIZE-th accepted tick. Minimum frame time is SIZE+2 cycles from start.
REQ-026 bit_tick held high for consecutive cycles shifts one bit per cycle.
REQ-027 Priority per cycle: rst > clear > start/bit_tick.
REQ-028 clear in any state -> next cycle:
- dataOut = 0.
- bit_cnt = 0.
- state = IDLE.
- No done pulse, even when coincident with the final tick.
REQ-029 lsb_first changes during SHIFT do not affect the frame in progress.

Reset
REQ-030 rst sampled high at a clock edge -> next cycle:
- state = IDLE.
- dataOut = 0.
- bit_cnt = 0.
- latched order = MSB-first.
- busy = 0.
- done = 0.
- Applies mid-frame too.
REQ-031 No asynchronous reset path exists; outputs change only on clk edges, except serOut, which follows dataOut.

Configuration
REQ-032 Macro SPI_SHIFT_LSB_FIRST_EN.
REQ-033 Defined: lsb_first behaves per REQ-008, REQ-020, REQ-022 and REQ-029.
REQ-034 Undefined:
- lsb_first is ignored.
- Order is always MSB-first.
- No order-latch register is synthesised.

Verification
REQ-035 SIZE=8, start with dataIn=0xA5, serIn=0, eight ticks:
- serOut = 1,0,1,0,0,1,0,1.
- done pulses once.
- dataOut = 0x00.
REQ-036 SIZE=8, serOut looped to serIn, dataIn=0x3C, ticks on alternate cycles:
- dataOut = 0x3C at done.
- busy high for 16 cycles.
REQ-037 With the macro defined, lsb_first=1, dataIn=0x01, serIn=1, eight ticks:
- serOut first bit = 1, then seven 0s.
- dataOut = 0xFF.
REQ-038 dataIn=0xFF, three ticks, then clear:
- Next cycle: dataOut=0, busy=0, bit_cnt=0.
- No done pulse.
REQ-039 start during SHIFT with dataIn=0x55 mid-frame:
- Frame continues unchanged.
- done occurs exactly SIZE ticks after the first start.
REQ-040 rst asserted after five ticks:
- Next cycle: all outputs zero, state IDLE.
- A subsequent start completes a normal frame.

Source files
------------

// File: rtl/spi_shift_engine.sv
// SPI shift engine: loads a parallel frame, shifts it out and shifts receive data in, one bit per bit_tick.
// Optional per-frame LSB-first ordering is enabled by defining SPI_SHIFT_LSB_FIRST_EN.
module spi_shift_engine #(
  parameter int SIZE  = 8,
  parameter int CNT_W = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             bit_tick,
  input  logic             lsb_first,
  input  logic             serIn,
  input  logic [SIZE-1:0]  dataIn,
  output logic             serOut,
  output logic [SIZE-1:0]  dataOut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q;

`ifdef SPI_SHIFT_LSB_FIRST_EN
  logic order_d;
`else
  // Order is fixed MSB-first; the select input has no effect in this build.
  logic unused_lsb_first;
  assign unused_lsb_first = lsb_first;
  assign order_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    order_d = order_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = dataIn;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SPI_SHIFT_LSB_FIRST_EN
          order_d = lsb_first;
`endif
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          data_d = order_q ? {serIn, data_q[SIZE-1:1]} : {data_q[SIZE-2:0], serIn};
          if (cnt_q == CNT_W'(SIZE-1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over any start or tick in the same cycle, suppressing done.
    if (clear) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SPI_SHIFT_LSB_FIRST_EN
  always_ff @(posedge clk) begin
    if (rst) order_q <= 1'b0;
    else     order_q <= order_d;
  end
`endif

  assign serOut  = order_q ? data_q[0] : data_q[SIZE-1];
  assign dataOut = data_q;
  assign bit_cnt = cnt_q;
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (SIZE=8); covers both builds of SPI_SHIFT_LSB_FIRST_EN.
module tb_spi_shift_engine;
  localparam int SIZE = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, start, clear, bit_tick, lsb_first, serIn;
  logic [SIZE-1:0]  dataIn;
  logic             serOut, busy, done;
  logic [SIZE-1:0]  dataOut;
  logic [CNT_W-1:0] bit_cnt;

  int n_chk = 0;
  int n_fail = 0;

  spi_shift_engine #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .bit_tick(bit_tick),
    .lsb_first(lsb_first), .serIn(serIn), .dataIn(dataIn), .serOut(serOut),
    .dataOut(dataOut), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; clear = 0; bit_tick = 0; lsb_first = 0; serIn = 0; dataIn = '0;
    cyc(); cyc();
    rst = 0;
    n_chk++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", dataOut); end
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b done %b want 0 0", busy, done); end
    n_chk++; if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    n_chk++; if (serOut !== 1'b0) begin n_fail++; $display("FAIL reset_serout: got %b want 0", serOut); end
    // Ticks in IDLE are ignored.
    bit_tick = 1; serIn = 1; cyc(); cyc(); bit_tick = 0;
    n_chk++; if (dataOut !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_tick: data %h busy %b want 00 0", dataOut, busy); end
  endtask

  task automatic test_msb_a5();
    logic [7:0] exp_bits;
    int dones;
    exp_bits = 8'b1010_0101;
    dones = 0;
    dataIn = 8'hA5; start = 1; cyc(); start = 0;
    n_chk++; if (dataOut !== 8'hA5 || busy !== 1'b1 || bit_cnt !== 3'd0) begin n_fail++; $display("FAIL a5_load: data %h busy %b cnt %0d want a5 1 0", dataOut, busy, bit_cnt); end
    serIn = 0;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (serOut !== exp_bits[7-i]) begin n_fail++; $display("FAIL a5_serout[%0d]: got %b want %b", i, serOut, exp_bits[7-i]); end
      bit_tick = 1; cyc();
      if (done) dones++;
      if (i < 7) begin
        n_chk++; if (bit_cnt !== 3'(i+1)) begin n_fail++; $display("FAIL a5_cnt[%0d]: got %0d want %0d", i, bit_cnt, i+1); end
      end
    end
    bit_tick = 0;
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || dataOut !== 8'h00 || bit_cnt !== 3'd0) begin n_fail++; $display("FAIL a5_done: done %b busy %b data %h cnt %0d want 1 0 00 0", done, busy, dataOut, bit_cnt); end
    cyc(); if (done) dones++;
    cyc(); if (done) dones++;
    n_chk++; if (dones != 1) begin n_fail++; $display("FAIL a5_done_count: got %0d want 1", dones); end
    n_chk++; if (busy !== 1'b0 || dataOut !== 8'h00) begin n_fail++; $display("FAIL a5_idle: busy %b data %h want 0 00", busy, dataOut); end
  endtask

  task automatic test_loopback();
    int busy_cycles;
    busy_cycles = 0;
    dataIn = 8'h3C; start = 1; cyc(); start = 0;
    if (busy) busy_cycles++;
    for (int i = 0; i < 8; i++) begin
      bit_tick = 0; serIn = serOut; cyc(); if (busy) busy_cycles++;
      bit_tick = 1; serIn = serOut; cyc(); if (busy) busy_cycles++;
    end
    bit_tick = 0;
    n_chk++; if (done !== 1'b1 || dataOut !== 8'h3C) begin n_fail++; $display("FAIL loop_done: done %b data %h want 1 3c", done, dataOut); end
    n_chk++; if (busy_cycles != 16) begin n_fail++; $display("FAIL loop_busy: got %0d cycles want 16", busy_cycles); end
    cyc();
  endtask

  task automatic test_order();
    lsb_first = 1; dataIn = 8'h01; start = 1; cyc(); start = 0;
    lsb_first = 0; serIn = 1;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
      n_chk++; if (serOut !== (i == 0)) begin n_fail++; $display("FAIL lsb_serout[%0d]: got %b want %b", i, serOut, (i == 0)); end
`else
      n_chk++; if (serOut !== (i == 7)) begin n_fail++; $display("FAIL msb_only_serout[%0d]: got %b want %b", i, serOut, (i == 7)); end
`endif
      bit_tick = 1; cyc();
    end
    bit_tick = 0;
    n_chk++; if (done !== 1'b1 || dataOut !== 8'hFF) begin n_fail++; $display("FAIL order_done: done %b data %h want 1 ff", done, dataOut); end
    serIn = 0; cyc();
  endtask

  task automatic test_clear();
    dataIn = 8'hFF; start = 1; cyc(); start = 0;
    serIn = 0; bit_tick = 1; cyc(); cyc(); cyc();
    bit_tick = 0; clear = 1; cyc(); clear = 0;
    n_chk++; if (dataOut !== 8'h00 || busy !== 1'b0 || bit_cnt !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL clear_mid: data %h busy %b cnt %0d done %b want 00 0 0 0", dataOut, busy, bit_cnt, done); end
    cyc();
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_nodone: got %b want 0", done); end
    // Clear coincident with the final tick.
    dataIn = 8'h96; start = 1; cyc(); start = 0;
    bit_tick = 1;
    for (int i = 0; i < 7; i++) cyc();
    clear = 1; cyc(); clear = 0; bit_tick = 0;
    n_chk++; if (done !== 1'b0 || busy !== 1'b0 || dataOut !== 8'h00) begin n_fail++; $display("FAIL clear_final: done %b busy %b data %h want 0 0 00", done, busy, dataOut); end
    cyc();
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_final_nodone: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    dataIn = 8'hA5; start = 1; cyc(); start = 0;
    serIn = 0; bit_tick = 1; cyc(); cyc(); cyc(); bit_tick = 0;
    dataIn = 8'h55; start = 1; cyc(); start = 0;
    n_chk++; if (dataOut !== 8'h28 || bit_cnt !== 3'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_ignored: data %h cnt %0d busy %b want 28 3 1", dataOut, bit_cnt, busy); end
    bit_tick = 1;
    for (int i = 0; i < 4; i++) cyc();
    n_chk++; if (done !== 1'b0 || bit_cnt !== 3'd7) begin n_fail++; $display("FAIL restart_early: done %b cnt %0d want 0 7", done, bit_cnt); end
    cyc(); bit_tick = 0;
    n_chk++; if (done !== 1'b1 || dataOut !== 8'h00) begin n_fail++; $display("FAIL restart_done: done %b data %h want 1 00", done, dataOut); end
    // Start during DONE is dropped.
    dataIn = 8'h55; start = 1; cyc(); start = 0;
    n_chk++; if (busy !== 1'b0 || dataOut !== 8'h00) begin n_fail++; $display("FAIL start_in_done: busy %b data %h want 0 00", busy, dataOut); end
  endtask

  task automatic test_reset_midframe();
    dataIn = 8'hC3; start = 1; cyc(); start = 0;
    serIn = 1; bit_tick = 1;
    for (int i = 0; i < 5; i++) cyc();
    bit_tick = 0;
    n_chk++; if (bit_cnt !== 3'd5 || dataOut !== 8'h7F) begin n_fail++; $display("FAIL pre_rst: cnt %0d data %h want 5 7f", bit_cnt, dataOut); end
    rst = 1; cyc(); rst = 0;
    n_chk++; if (dataOut !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || bit_cnt !== 3'd0 || serOut !== 1'b0) begin n_fail++; $display("FAIL mid_rst: data %h busy %b done %b cnt %0d ser %b want 00 0 0 0 0", dataOut, busy, done, bit_cnt, serOut); end
    dataIn = 8'h81; start = 1; cyc(); start = 0;
    n_chk++; if (serOut !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL post_rst_load: ser %b busy %b want 1 1", serOut, busy); end
    serIn = 0; bit_tick = 1;
    for (int i = 0; i < 8; i++) cyc();
    bit_tick = 0;
    n_chk++; if (done !== 1'b1 || dataOut !== 8'h00) begin n_fail++; $display("FAIL post_rst_frame: done %b data %h want 1 00", done, dataOut); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_msb_a5();
    test_loopback();
    test_order();
    test_clear();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
